// File: rtl/ebi_pkg.sv
// Shared types and constants for the external-bus cycle decoder.
package ebi_pkg;

    localparam int EBI_ADDR_W = 8;
    localparam int EBI_DATA_W = 8;
    localparam int EBI_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_ACT    = 3'd1,
        ST_WR_COMMIT = 3'd2,
        ST_RD_ISSUE  = 3'd3,
        ST_RD_WAIT   = 3'd4,
        ST_RD_HOLD   = 3'd5
    } ebi_state_e;

endpackage

// File: rtl/ebi_sync_filter.sv
// Single-strobe synchroniser with optional deglitch filter.
// Optional feature macro: EBI_DEGLITCH_EN (filtered level follows the
// synchronised level only after FILT_LEN consecutive stable cycles).
module ebi_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

`ifdef EBI_DEGLITCH_EN
    localparam bit DEGLITCH = 1'b1;
`else
    localparam bit DEGLITCH = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] sync_q;

    // Metastability chain; resets to the inactive (high) strobe level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    generate
        if (DEGLITCH && (FILT_LEN > 0)) begin : g_filt
            localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
            logic [CW-1:0] cnt_q;
            logic          filt_q;

            // Adopt a new level only after it has persisted FILT_LEN cycles.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(FILT_LEN - 1)) begin
                    cnt_q  <= '0;
                    filt_q <= sync_q[SYNC_STAGES-1];
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            assign sync_o = filt_q;
        end else begin : g_nofilt
            assign sync_o = sync_q[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ebi_cycle_decoder.sv
// External-bus cycle decoder: synchronises CS/WR/RD, turns complete bus
// cycles into single-cycle RAM requests, drives the IOBUF tristate for reads,
// and keeps cycle counters plus a sticky protocol-error flag.
// Optional feature macro: EBI_DEGLITCH_EN (strobe deglitch, see ebi_sync_filter).
module ebi_cycle_decoder
    import ebi_pkg::*;
#(
    parameter int ADDR_W      = EBI_ADDR_W,
    parameter int DATA_W      = EBI_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1,
    parameter int FILT_LEN    = 3
) (
    input  logic              CLK_50Mhz,
    input  logic              RST,
    input  logic              CS,
    input  logic              WR,
    input  logic              RD,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_T,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              clr_err,
    output logic              proto_err,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
);

    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic cs_s, wr_s, rd_s;

    ebi_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sync_cs (
        .clk_i(CLK_50Mhz), .rst_i(RST), .async_i(CS), .sync_o(cs_s)
    );
    ebi_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sync_wr (
        .clk_i(CLK_50Mhz), .rst_i(RST), .async_i(WR), .sync_o(wr_s)
    );
    ebi_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sync_rd (
        .clk_i(CLK_50Mhz), .rst_i(RST), .async_i(RD), .sync_o(rd_s)
    );

    ebi_state_e           state_q;
    logic                 mem_en_q, mem_we_q, data_T_q, err_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q, rdata_q;
    logic [EBI_CNT_W-1:0] wr_cnt_q, rd_cnt_q;
    logic [LW-1:0]        lat_q;

    // Bus-cycle FSM with all outputs registered; a later error assignment
    // overrides the clr_err clear so an error in the clearing cycle sticks.
    always_ff @(posedge CLK_50Mhz or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            data_T_q <= 1'b1;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            lat_q    <= '0;
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (clr_err) begin
                err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    data_T_q <= 1'b1;
                    if (!cs_s) begin
                        if (!wr_s && !rd_s) begin
                            err_q <= 1'b1;
                        end else if (!wr_s) begin
                            state_q <= ST_WR_ACT;
                            addr_q  <= address;
                            wdata_q <= data_in;
                        end else if (!rd_s) begin
                            state_q  <= ST_RD_ISSUE;
                            addr_q   <= address;
                            mem_en_q <= 1'b1;
                        end
                    end
                end
                ST_WR_ACT: begin
                    if (wr_s) begin
                        state_q  <= ST_WR_COMMIT;
                        mem_en_q <= 1'b1;
                        mem_we_q <= 1'b1;
                    end else if (cs_s || !rd_s) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        addr_q  <= address;
                        wdata_q <= data_in;
                    end
                end
                ST_WR_COMMIT: begin
                    wr_cnt_q <= wr_cnt_q + EBI_CNT_W'(1);
                    state_q  <= ST_IDLE;
                end
                ST_RD_ISSUE: begin
                    if (!wr_s) begin
                        state_q  <= ST_IDLE;
                        err_q    <= 1'b1;
                        data_T_q <= 1'b1;
                    end else begin
                        state_q <= ST_RD_WAIT;
                        lat_q   <= '0;
                    end
                end
                ST_RD_WAIT: begin
                    if (!wr_s) begin
                        state_q  <= ST_IDLE;
                        err_q    <= 1'b1;
                        data_T_q <= 1'b1;
                    end else if (lat_q == LW'(RD_LAT - 1)) begin
                        state_q  <= ST_RD_HOLD;
                        rdata_q  <= mem_rdata;
                        data_T_q <= cs_s | rd_s;
                    end else begin
                        lat_q <= lat_q + LW'(1);
                    end
                end
                ST_RD_HOLD: begin
                    if (!wr_s) begin
                        state_q  <= ST_IDLE;
                        err_q    <= 1'b1;
                        data_T_q <= 1'b1;
                    end else if (cs_s || rd_s) begin
                        state_q  <= ST_IDLE;
                        data_T_q <= 1'b1;
                        rd_cnt_q <= rd_cnt_q + EBI_CNT_W'(1);
                    end else begin
                        data_T_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    data_T_q <= 1'b1;
                end
            endcase
        end
    end

    assign data_out  = rdata_q;
    assign data_T    = data_T_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign proto_err = err_q;
    assign wr_cnt    = wr_cnt_q;
    assign rd_cnt    = rd_cnt_q;

endmodule

// File: tb/tb_ebi_cycle_decoder.sv
// Directed self-checking bench for ebi_cycle_decoder (default parameters).
module tb_ebi_cycle_decoder;

`ifdef EBI_DEGLITCH_EN
    localparam int FL = 3;
`else
    localparam int FL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, wr, rd, clr_err;
    logic [7:0]  address, data_in, data_out, mem_addr, mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        data_T, mem_en, mem_we, proto_err;
    logic [15:0] wr_cnt, rd_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int en_cnt = 0;
    int we_cnt = 0;

    always #10 clk = ~clk;

    ebi_cycle_decoder dut (
        .CLK_50Mhz(clk), .RST(rst), .CS(cs), .WR(wr), .RD(rd),
        .address(address), .data_in(data_in), .data_out(data_out),
        .data_T(data_T), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .clr_err(clr_err), .proto_err(proto_err),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    // RAM model with one cycle of read latency: content is addr ^ 0x66,
    // so address 0x3C reads back 0x5A. Also counts RAM accesses.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem_addr ^ 8'h66;
            en_cnt    <= en_cnt + 1;
            if (mem_we) we_cnt <= we_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        cs = 1'b0; wr = 1'b0; address = a; data_in = d;
        repeat (6 + FL) tick();
        cs = 1'b1; wr = 1'b1;
        repeat (6 + FL) tick();
    endtask

    initial begin
        int base_en, base_we, k;
        rst = 1'b1; cs = 1'b1; wr = 1'b1; rd = 1'b1; clr_err = 1'b0;
        address = 8'h00; data_in = 8'h00;
        repeat (2) tick();
        check("rst_data_T", data_T, 1);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_rd_cnt", rd_cnt, 0);
        check("rst_data_out", data_out, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        repeat (3) tick();

        // Write cycle: WR low for 10 cycles, pulse 3 cycles after WR rises.
        base_we = we_cnt;
        cs = 1'b0; address = 8'h3C; data_in = 8'hA5; wr = 1'b0;
        repeat (10) tick();
        check("wr_act_data_T", data_T, 1);
        wr = 1'b1;
        for (int i = 0; i < 2 + FL; i++) begin
            tick();
            check("wr_no_early_en", mem_en, 0);
        end
        tick();
        check("wr_pulse_en", mem_en, 1);
        check("wr_pulse_we", mem_we, 1);
        check("wr_pulse_addr", mem_addr, 8'h3C);
        check("wr_pulse_data", mem_wdata, 8'hA5);
        tick();
        check("wr_pulse_end", mem_en, 0);
        cs = 1'b1;
        repeat (4) tick();
        check("wr_cnt_1", wr_cnt, 1);
        check("wr_single_pulse", we_cnt - base_we, 1);

        // Read cycle: RD low for 12 cycles at 0x3C.
        base_en = en_cnt; base_we = we_cnt;
        cs = 1'b0; rd = 1'b0; address = 8'h3C;
        for (int i = 0; i < 2 + FL; i++) begin
            tick();
            check("rd_no_early_en", mem_en, 0);
        end
        tick();
        check("rd_issue_en", mem_en, 1);
        check("rd_issue_we", mem_we, 0);
        check("rd_issue_addr", mem_addr, 8'h3C);
        tick();
        check("rd_wait_T", data_T, 1);
        tick();
        check("rd_hold_T", data_T, 0);
        check("rd_hold_data", data_out, 8'h5A);
        repeat (7) tick();
        check("rd_hold_T_late", data_T, 0);
        cs = 1'b1; rd = 1'b1;
        repeat (2 + FL) tick();
        check("rd_release_T_still0", data_T, 0);
        tick();
        check("rd_release_T", data_T, 1);
        check("rd_cnt_1", rd_cnt, 1);
        repeat (3) tick();
        check("rd_single_access", en_cnt - base_en, 1);
        check("rd_no_write", we_cnt - base_we, 0);

        // Conflict: WR and RD low together.
        base_en = en_cnt;
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        repeat (8 + FL) tick();
        check("conf_err", proto_err, 1);
        check("conf_T", data_T, 1);
        cs = 1'b1; wr = 1'b1; rd = 1'b1;
        repeat (8 + FL) tick();
        check("conf_no_access", en_cnt - base_en, 0);
        check("conf_sticky", proto_err, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("clr_err_clears", proto_err, 0);
        cs = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b1;
        repeat (8 + FL) tick();
        check("conf_beats_clr", proto_err, 1);
        clr_err = 1'b0; cs = 1'b1; wr = 1'b1; rd = 1'b1;
        repeat (8 + FL) tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("clr_err_again", proto_err, 0);

        // Abort: CS rises while WR still low.
        base_we = we_cnt;
        cs = 1'b0; wr = 1'b0; address = 8'h11; data_in = 8'h22;
        repeat (5 + FL) tick();
        cs = 1'b1;
        repeat (4 + FL) tick();
        wr = 1'b1;
        repeat (6 + FL) tick();
        check("abort_err", proto_err, 1);
        check("abort_no_we", we_cnt - base_we, 0);
        check("abort_wr_cnt", wr_cnt, 1);

        // Counter wrap.
        force dut.wr_cnt_q = 16'hFFFF;
        #1;
        release dut.wr_cnt_q;
        tick();
        check("wrap_preload", wr_cnt, 16'hFFFF);
        do_write(8'h42, 8'h99);
        check("wrap_zero", wr_cnt, 0);
        check("wrap_wdata", mem_wdata, 8'h99);
        do_write(8'h43, 8'h98);
        check("wrap_one", wr_cnt, 1);

`ifdef EBI_DEGLITCH_EN
        // Two-cycle WR glitch is filtered out.
        base_en = en_cnt;
        cs = 1'b0; wr = 1'b0;
        repeat (2) tick();
        wr = 1'b1;
        repeat (12) tick();
        cs = 1'b1;
        repeat (6) tick();
        check("glitch_no_access", en_cnt - base_en, 0);
        check("glitch_wr_cnt", wr_cnt, 1);
`endif

        // Reset while holding read data on the bus.
        cs = 1'b0; rd = 1'b0; address = 8'h10;
        k = 0;
        while (data_T !== 1'b0 && k < 30) begin
            tick();
            k++;
        end
        check("mid_rd_reach_hold", data_T, 0);
        check("mid_rd_data", data_out, 8'h76);
        #2;
        rst = 1'b1;
        #2;
        check("mid_rst_T", data_T, 1);
        check("mid_rst_wr_cnt", wr_cnt, 0);
        check("mid_rst_rd_cnt", rd_cnt, 0);
        check("mid_rst_err", proto_err, 0);
        check("mid_rst_state", 32'(dut.state_q), 0);
        cs = 1'b1; rd = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("post_rst_T", data_T, 1);
        check("post_rst_rd_cnt", rd_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
